// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: mode and FSM encodings plus the colour-bar palette
package pattern_gen_pkg;
    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_SOLID    = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_BARS     = 2'd3
    } mode_t;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_DONE    = 2'd2,
        S_CLEANUP = 2'd3
    } state_t;
    localparam logic [0:7][23:0] BAR_COLORS = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
endpackage

// File: rtl/pattern_coord_counter.sv
// pattern_coord_counter: raster x/y position and colour-bar index for the pixel being emitted
module pattern_coord_counter #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_advance,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic [2:0]   o_bar,
    output logic         o_last_pixel
);
    localparam int BW = H_RES / 8;
    localparam int CW = $clog2(BW + 1);
    logic [W-1:0]  r_x, r_y;
    logic [2:0]    r_bar;
    logic [CW-1:0] r_bar_cnt;
    logic          w_line_end, w_bar_end;
    assign w_line_end = r_x == W'(H_RES - 1);
    assign w_bar_end  = r_bar_cnt == CW'(BW - 1);
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_x       <= '0;
            r_y       <= '0;
            r_bar     <= '0;
            r_bar_cnt <= '0;
        end else if (i_advance) begin
            r_x       <= w_line_end ? '0 : r_x + 1'b1;
            r_y       <= w_line_end ? r_y + 1'b1 : r_y;
            r_bar_cnt <= (w_line_end || w_bar_end) ? '0 : r_bar_cnt + 1'b1;
            r_bar     <= w_line_end ? '0 : w_bar_end ? r_bar + 1'b1 : r_bar;
        end
    end
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_bar        = r_bar;
    assign o_last_pixel = w_line_end && r_y == W'(V_RES - 1);
endmodule

// File: rtl/pattern_fill_generator.sv
// pattern_fill_generator: streams one frame of pattern words into frame memory per enable,
// stalling on the arbiter pause and handshaking completion through done.
module pattern_fill_generator
    import pattern_gen_pkg::*;
#(
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int ADDR_W    = 18,
    parameter int TILE_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] starting_address,
    input  logic [23:0]       fill_color,
    output logic [31:0]       data_write,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    output logic              done
);
    localparam int XW = $clog2(H_RES) > TILE_LOG2 + 1 ? $clog2(H_RES) : TILE_LOG2 + 1;
    localparam int W  = $clog2(V_RES) > XW ? $clog2(V_RES) : XW;
    state_t            r_state;
    mode_t             r_mode;
    logic [ADDR_W-1:0] r_ptr;
    logic [23:0]       r_color, r_k;
    logic [W-1:0]      w_x, w_y;
    logic [2:0]        w_bar;
    logic              w_last, w_odd_tile;
    logic [23:0]       w_rgb;
    pattern_coord_counter #(.H_RES(H_RES), .V_RES(V_RES), .W(W)) u_coord (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (!pause && r_state == S_IDLE && enable),
        .i_advance    (!pause && r_state == S_WRITE),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_bar        (w_bar),
        .o_last_pixel (w_last)
    );
    // Tile parity is bit TILE_LOG2 of x xor y.
    assign w_odd_tile = |(((w_x ^ w_y) >> TILE_LOG2) & W'(1));
    assign w_rgb = r_mode == MODE_GRADIENT ? r_k :
                   r_mode == MODE_SOLID    ? r_color :
                   r_mode == MODE_CHECKER  ? (w_odd_tile ? r_color : 24'h0) :
                   BAR_COLORS[w_bar];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            data_write <= '0;
            addr       <= '0;
            wren       <= 1'b0;
            done       <= 1'b0;
        end else if (pause) begin
            wren <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    data_write <= '0;
                    addr       <= '0;
                    wren       <= 1'b0;
                    done       <= 1'b0;
                    if (enable) begin
                        r_mode  <= mode_t'(mode);
                        r_ptr   <= starting_address;
                        r_color <= fill_color;
                        r_k     <= '0;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wren       <= 1'b1;
                    addr       <= r_ptr;
                    data_write <= {w_rgb, 8'h00};
                    r_ptr      <= r_ptr + 1'b1;
                    r_k        <= r_k + 1'b1;
                    if (w_last) r_state <= S_DONE;
                end
                S_DONE: begin
                    data_write <= '0;
                    addr       <= '0;
                    wren       <= 1'b0;
                    done       <= 1'b1;
                    r_state    <= S_CLEANUP;
                end
                default: begin
                    if (!enable) begin
                        done    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_fill_generator.sv
// tb_pattern_fill_generator: random frames on a 16x16 and a default-size generator,
// checked against an arithmetic pixel model.
module tb_pattern_fill_generator;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst [2];
    logic        pse [2];
    logic        en  [2];
    logic [1:0]  md  [2];
    logic [17:0] bs  [2];
    logic [23:0] col [2];
    logic [31:0] dw  [2];
    logic [17:0] ad  [2];
    logic        we  [2];
    logic        dn  [2];
    int n_chk = 0;
    int n_fail = 0;

    pattern_fill_generator #(.H_RES(320), .V_RES(240), .ADDR_W(18), .TILE_LOG2(3)) u_big (
        .clk(clk), .reset(rst[0]), .pause(pse[0]), .enable(en[0]), .mode(md[0]),
        .starting_address(bs[0]), .fill_color(col[0]),
        .data_write(dw[0]), .addr(ad[0]), .wren(we[0]), .done(dn[0]));
    pattern_fill_generator #(.H_RES(16), .V_RES(16), .ADDR_W(18), .TILE_LOG2(3)) u_small (
        .clk(clk), .reset(rst[1]), .pause(pse[1]), .enable(en[1]), .mode(md[1]),
        .starting_address(bs[1]), .fill_color(col[1]),
        .data_write(dw[1]), .addr(ad[1]), .wren(we[1]), .done(dn[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int hres(input int u);
        return u == 0 ? 320 : 16;
    endfunction
    function automatic int vres(input int u);
        return u == 0 ? 240 : 16;
    endfunction
    function automatic logic [63:0] obs(input int u);
        return 64'({dn[u], we[u], ad[u], dw[u]});
    endfunction
    function automatic logic [63:0] ev(input logic d, input logic w, input logic [17:0] a, input logic [31:0] data);
        return 64'({d, w, a, data});
    endfunction

    function automatic logic [31:0] px(input int u, input int m, input int k, input logic [23:0] c);
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        int h = hres(u);
        int x = k % h;
        int y = k / h;
        logic [23:0] rgb;
        if (m == 0) rgb = 24'(k);
        else if (m == 1) rgb = c;
        else if (m == 2) rgb = ((x / 8 + y / 8) % 2) ? c : 24'h0;
        else rgb = bars[x / (h / 8)];
        return {rgb, 8'h00};
    endfunction

    task automatic run_frame(input int u, input int m, input logic [17:0] b, input logic [23:0] c,
                             input int p_at, input int p_len, input bit rnd_p,
                             input bit drop_early, input int hold);
        int n = hres(u) * vres(u);
        int k = 0;
        int pl = 0;
        int cyc = 0;
        bit pdone = 0;
        bit was_p;
        logic [49:0] prev;
        logic [17:0] ea;
        @(negedge clk);
        md[u] = 2'(m); bs[u] = b; col[u] = c; en[u] = 1'b1; pse[u] = 1'b0;
        @(negedge clk);
        check("start_idle", obs(u), 64'h0);
        md[u] = 2'($urandom); bs[u] = 18'($urandom); col[u] = 24'($urandom);
        if (drop_early) en[u] = 1'b0;
        prev = {ad[u], dw[u]};
        while (k < n && cyc < n + 1000) begin
            if (!pdone && p_len > 0 && k == p_at) begin pl = p_len; pdone = 1; end
            if (pl > 0) begin pse[u] = 1'b1; pl--; end
            else pse[u] = rnd_p && ($urandom_range(0, 5) == 0);
            was_p = pse[u];
            @(negedge clk);
            cyc++;
            if (was_p) check("pause_hold", obs(u), ev(1'b0, 1'b0, prev[49:32], prev[31:0]));
            else begin
                ea = b + 18'(k);
                check("write", obs(u), ev(1'b0, 1'b1, ea, px(u, m, k, c)));
                k++;
            end
            prev = {ad[u], dw[u]};
        end
        check("write_count", 64'(k), 64'(n));
        pse[u] = 1'b0;
        @(negedge clk);
        check("done_rise", obs(u), ev(1'b1, 1'b0, 18'h0, 32'h0));
        if (!drop_early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("done_hold", obs(u), ev(1'b1, 1'b0, 18'h0, 32'h0));
            end
            en[u] = 1'b0;
        end
        @(negedge clk);
        check("done_fall", obs(u), 64'h0);
        @(negedge clk);
    endtask

    task automatic reset_mid(input int u, input logic [17:0] b);
        @(negedge clk);
        md[u] = 2'd0; bs[u] = b; col[u] = 24'h0; en[u] = 1'b1; pse[u] = 1'b0;
        repeat (51) @(negedge clk);
        check("pre_reset_write", obs(u), ev(1'b0, 1'b1, b + 18'd49, px(u, 0, 49, 24'h0)));
        rst[u] = 1'b1; pse[u] = 1'b1; en[u] = 1'b0;
        @(negedge clk);
        check("reset_out", obs(u), 64'h0);
        rst[u] = 1'b0; pse[u] = 1'b0;
        @(negedge clk);
        run_frame(u, 0, b, 24'h0, -1, 0, 0, 0, 1);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; pse[u] = 1'b0; en[u] = 1'b0;
            md[u] = 2'd0; bs[u] = 18'h0; col[u] = 24'h0;
        end
        repeat (2) @(negedge clk);
        check("reset_big", obs(0), 64'h0);
        check("reset_small", obs(1), 64'h0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        run_frame(1, 0, 18'h00010, 24'h0, -1, 0, 0, 0, 2);
        run_frame(1, 3, 18'h01000, 24'h0, -1, 0, 1, 1, 0);
        run_frame(1, 2, 18'h02000, 24'h123456, -1, 0, 0, 0, 0);
        run_frame(1, 1, 18'($urandom), 24'($urandom), -1, 0, 1, 0, 1);
        run_frame(1, 0, 18'h3FFFC, 24'h0, 5, 2, 0, 0, 3);
        reset_mid(1, 18'h00400);
        for (int i = 0; i < 6; i++)
            run_frame(1, $urandom_range(0, 3), 18'($urandom), 24'($urandom), -1, 0, 1,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        run_frame(0, 3, 18'h00100, 24'h0, 100, 3, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_fill_generator.md
# pattern_fill_generator

Parametrised frame-buffer pattern writer. On `enable` it streams one full frame of `H_RES*V_RES` 32-bit pixel words into frame memory from `starting_address`, one word per unpaused cycle. It supports four selectable patterns: gradient, solid, checkerboard and colour bars. It sits beside the other memory-client engines on the shared SRAM write port and honours the arbiter's `pause`. It signals completion with a `done` level held until `enable` drops.

## Interface
- `H_RES`, 320, pixels per line; must be a multiple of 8 and at least 8.
- `V_RES`, 240, lines per frame; at least 1.
- `ADDR_W`, 18, memory address width.
- `TILE_LOG2`, 3, log2 of checkerboard tile edge in pixels.
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high; overrides `pause`.
- `pause` in 1: arbiter stall; freezes all state.
- `enable` in 1: start request (level); acknowledged via `done`.
- `mode` in 2: 0 gradient, 1 solid, 2 checkerboard, 3 colour bars; sampled at start.
- `starting_address` in ADDR_W: base word address; sampled at start.
- `fill_color` in 24: RGB for solid/checkerboard; sampled at start.
- `data_write` out 32: pixel word `{RGB[23:0], 8'h00}`.
- `addr` out ADDR_W: write address.
- `wren` out 1: write strobe, one word per cycle high.
- `done` out 1: frame complete.

## Operation
- States: IDLE, WRITE, DONE, CLEANUP.
- IDLE:
  - Outputs are 0.
  - On `enable`=1, latch `mode`, `starting_address` and `fill_color`, clear the pixel index, x, y and bar counters, then go to WRITE.
- WRITE, each unpaused edge:
  - Drive `wren`=1, `addr`=base+k (mod 2^ADDR_W) and the pattern word for pixel k, then k++.
  - After pixel k=N-1 (N=H_RES*V_RES), go to DONE.
  - Exactly N writes per frame, with no gaps except pauses.
- DONE: `wren`=0, `addr`=0, `data_write`=0, `done`=1; go to CLEANUP.
- CLEANUP:
  - Hold `done`=1 while `enable`=1.
  - When `enable`=0, `done`=0 and go to IDLE.
- Patterns, with x in 0..H_RES-1, y in 0..V_RES-1 and k=y*H_RES+x:
  - Gradient: RGB = k[23:0].
  - Solid: RGB = `fill_color`.
  - Checkerboard: RGB = `fill_color` if `x[TILE_LOG2]^y[TILE_LOG2]` is 1, else 24'h0.
  - Colour bars: bar index b = x/(H_RES/8), produced by a counter, not a divider. Colours for b=0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- `enable` dropping during WRITE is ignored; the frame completes, then `done` pulses for one cycle.
- Input changes after start do not affect the frame in progress.

## Timing
- `reset`: state IDLE; `data_write`, `addr`, `wren` and `done` all 0 on the next edge.
- `pause`=1 on an edge: no state or counter change and `addr`/`data_write` hold. In WRITE `wren` is forced to 0 for that cycle, so a paused cycle never produces a write. Outside WRITE all outputs simply hold.
- Latency:
  - Edge 0: `enable` sampled in IDLE.
  - Edge 1: first write (pixel 0) on outputs.
  - Edge N: last write.
  - Edge N+1: `done`=1 and `wren`=0.
  - Each pause cycle adds one cycle.
- Next frame: at least one IDLE cycle after `done` falls, before a new `enable` is sampled.
- Address wrap past 2^ADDR_W-1 goes to 0 silently.

## Structure
- Package `pattern_gen_pkg` holds the mode encodings, state encodings and the 8-entry colour-bar constant table.
- Sub-module `pattern_coord_counter` holds the x/y/bar counters with clear and advance inputs. It exposes x, y, bar index and `last_pixel`.
- The top level contains the FSM, the input latches and the pattern mux.

## Test plan
- Gradient, H_RES=8, V_RES=2, base 0x10, no pause:
  - Writes on 16 consecutive cycles, addr 0x10..0x1F, data = k<<8.
  - `done`=1 one cycle after the last write.
- Pause mid-frame (default size), `pause` high for 3 cycles at k=100:
  - `wren`=0 for exactly those cycles and no address skipped or repeated.
  - Total writes 76800; `done` delayed by 3 cycles.
- Colour bars, H_RES=16, V_RES=1: pixels 0-1 give 0xFFFFFF00, pixels 2-3 give 0xFFFF0000, and so on to 14-15 giving 0x00000000.
- Checkerboard, H_RES=16, V_RES=16, `fill_color`=0x123456:
  - (x=8,y=0) gives 0x12345600.
  - (x=8,y=8) gives 0.
  - (x=0,y=8) gives 0x12345600.
- `reset` asserted at k=50 with `pause` also high: all outputs 0 next edge.
  - A new `enable` restarts from the latched base at k=0.
- Base 2^18-4, H_RES=8, V_RES=1: addresses 3FFFC..3FFFF, then 0..3.
  - `enable` held high holds `done`=1; `done` clears the cycle after `enable` drops.
